// File: rtl/joy_serial_responder_pkg.sv
// Shared types and constants for the joystick serial responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package joy_serial_pkg;

    localparam int   JOY_WIDTH = 24;
    localparam int   CNT_W     = $clog2(JOY_WIDTH + 1);
    localparam logic FILL_DEF  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/joy_serial_responder_if.sv
// MCU-facing serial pins plus core-facing joystick word and status, bundled as one port.
// Latency: n/a (wires only).
// Backpressure: none; the MCU owns the shift timing.
interface joy_serial_responder_if;
    import joy_serial_pkg::*;

    logic                 XJOY_CLK;
    logic                 XJOY_LOAD_N;
    logic                 XJOY_DATA;
    logic [JOY_WIDTH-1:0] joy_state;
    logic                 joy_valid;
    logic                 frame_done;
    logic                 overrun;
    logic [CNT_W-1:0]     bit_cnt;

    modport master (
        output XJOY_CLK, XJOY_LOAD_N, joy_state, joy_valid,
        input  XJOY_DATA, frame_done, overrun, bit_cnt
    );

    modport slave (
        input  XJOY_CLK, XJOY_LOAD_N, joy_state, joy_valid,
        output XJOY_DATA, frame_done, overrun, bit_cnt
    );

endinterface

// File: rtl/joy_serial_responder_sync.sv
// Synchronises one async MCU pin, then requires FILTER extra stable clocks before accepting a change.
// Latency: edge_o fires SYNC_STAGES+FILTER+1 clocks after the pin changes; level_o updates on that same edge.
// Backpressure: none; pulses shorter than FILTER+1 synchronised clocks are dropped.
module joy_sync_filter #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILTER      = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic edge_o
);

    localparam int FW = (FILTER < 1) ? 1 : $clog2(FILTER + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q;
    logic [FW-1:0]          cnt_q;
    logic                   sync_bit;
    logic                   accept;

    assign sync_bit = sync_q[SYNC_STAGES-1];
    // A change is taken once the synchronised value has differed for FILTER+1 consecutive clocks.
    assign accept   = (sync_bit != level_q) && (cnt_q == FW'(FILTER));

    // Metastability chain for the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

    // Stability counter: any return to the accepted level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= RST_VAL;
            cnt_q   <= '0;
        end else if (sync_bit == level_q) begin
            cnt_q   <= '0;
        end else if (accept) begin
            level_q <= sync_bit;
            cnt_q   <= '0;
        end else begin
            cnt_q   <= cnt_q + FW'(1);
        end
    end

    // level_o still holds the old level during edge_o, so the caller can tell rise from fall.
    assign level_o = level_q;
    assign edge_o  = accept;

endmodule

// File: rtl/joy_serial_responder.sv
// Emulates a 74HC165 chain on XJOY_DATA: load on LOAD_N low, shift MSB first on each XJOY_CLK rise.
// Latency: action SYNC_STAGES+FILTER+1 clocks after the MCU edge, XJOY_DATA one clock after that.
// Backpressure: none; shifts past the frame end drive FILL and set sticky overrun until the next load.
module joy_serial_responder
    import joy_serial_pkg::*;
#(
    parameter int   WIDTH       = JOY_WIDTH,
    parameter int   SYNC_STAGES = 2,
    parameter int   FILTER      = 2,
    parameter logic FILL        = FILL_DEF
) (
    input  logic                   CLOCK_50,
    input  logic                   RESET_N,
    joy_serial_responder_if.slave  jif
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] stage_q;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             overrun_q, overrun_d;
    logic             frame_done_q, frame_done_d;
    logic             data_q;

    logic clk_level, clk_edge, load_level, load_edge;
    logic clk_rise, load_fall, load_rise;

    joy_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER(FILTER), .RST_VAL(1'b0)) u_clk_sync (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .async_i (jif.XJOY_CLK),
        .level_o (clk_level),
        .edge_o  (clk_edge)
    );

    joy_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER(FILTER), .RST_VAL(1'b1)) u_load_sync (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .async_i (jif.XJOY_LOAD_N),
        .level_o (load_level),
        .edge_o  (load_edge)
    );

    assign clk_rise  = clk_edge  & ~clk_level;
    assign load_fall = load_edge &  load_level;
    assign load_rise = load_edge & ~load_level;

    // Staging register holds the last word the core presented.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            stage_q <= {WIDTH{FILL}};
        end else if (jif.joy_valid) begin
            stage_q <= jif.joy_state;
        end
    end

    // Next state: loading dominates everything, including a coincident clock rise.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        overrun_d    = overrun_q;
        frame_done_d = 1'b0;
        if (load_fall || (state_q == LOAD && !load_rise)) begin
            state_d   = LOAD;
            shreg_d   = jif.joy_valid ? jif.joy_state : stage_q;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                LOAD: state_d = SHIFT;
                SHIFT: begin
                    if (clk_rise) begin
                        shreg_d = {shreg_q[WIDTH-2:0], FILL};
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_d == CNT_W'(WIDTH)) begin
                            state_d      = DONE;
                            frame_done_d = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (clk_rise) begin
                        overrun_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, shift register, counters and the registered serial output.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            shreg_q      <= {WIDTH{FILL}};
            cnt_q        <= '0;
            overrun_q    <= 1'b0;
            frame_done_q <= 1'b0;
            data_q       <= FILL;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            overrun_q    <= overrun_d;
            frame_done_q <= frame_done_d;
            data_q       <= (state_q == LOAD || state_q == SHIFT) ? shreg_q[WIDTH-1] : FILL;
        end
    end

    assign jif.XJOY_DATA  = data_q;
    assign jif.frame_done = frame_done_q;
    assign jif.overrun    = overrun_q;
    assign jif.bit_cnt    = cnt_q;

endmodule

// File: tb/tb_joy_serial_responder.sv
// Directed bench for joy_serial_responder: acts as the MCU and the core side.
// Latency: MCU half-period is 8 system clocks, comfortably above the input filter.
// Backpressure: n/a.
module tb_joy_serial_responder;
    import joy_serial_pkg::*;

    logic CLOCK_50 = 1'b0;
    logic RESET_N  = 1'b0;
    int   checks   = 0;
    int   errors   = 0;
    int   fd_cnt   = 0;
    int   fd_base  = 0;

    joy_serial_responder_if jif();

    joy_serial_responder dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .jif      (jif)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        if (jif.frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic stage(input logic [23:0] v);
        jif.joy_state = v;
        jif.joy_valid = 1'b1;
        cyc(1);
        jif.joy_valid = 1'b0;
    endtask

    task automatic mcu_clk();
        jif.XJOY_CLK = 1'b1;
        cyc(8);
        jif.XJOY_CLK = 1'b0;
        cyc(8);
    endtask

    task automatic mcu_load();
        jif.XJOY_LOAD_N = 1'b0;
        cyc(8);
        jif.XJOY_LOAD_N = 1'b1;
        cyc(8);
    endtask

    // Reads a full frame after a load: bit 23 before any clock, then one bit per clock.
    task automatic read_frame(input int mid_k, input logic [23:0] mid_v, output logic [23:0] w);
        w     = '0;
        w[23] = jif.XJOY_DATA;
        for (int i = 1; i <= 24; i++) begin
            if (i == mid_k) stage(mid_v);
            mcu_clk();
            if (i < 24) w[23-i] = jif.XJOY_DATA;
        end
    endtask

    task automatic test_reset();
        cyc(2);
        checks++; if (jif.XJOY_DATA !== 1'b1) begin errors++; $display("FAIL reset_data: got %b expected 1", jif.XJOY_DATA); end
        checks++; if (jif.bit_cnt !== 5'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", jif.bit_cnt); end
        checks++; if (jif.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", jif.overrun); end
        checks++; if (jif.frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", jif.frame_done); end
        RESET_N = 1'b1;
        cyc(2);
        for (int i = 0; i < 10; i++) mcu_clk();
        checks++; if (jif.XJOY_DATA !== 1'b1) begin errors++; $display("FAIL idle_data: got %b expected 1", jif.XJOY_DATA); end
        checks++; if (jif.bit_cnt !== 5'd0) begin errors++; $display("FAIL idle_cnt: got %0d expected 0", jif.bit_cnt); end
    endtask

    task automatic test_frame();
        logic [23:0] w;
        stage(24'hA5F00F);
        fd_base = fd_cnt;
        mcu_load();
        read_frame(-1, 24'h0, w);
        checks++; if (w !== 24'hA5F00F) begin errors++; $display("FAIL frame_word: got %h expected a5f00f", w); end
        checks++; if (fd_cnt - fd_base !== 1) begin errors++; $display("FAIL frame_done_count: got %0d expected 1", fd_cnt - fd_base); end
        checks++; if (jif.bit_cnt !== 5'd24) begin errors++; $display("FAIL frame_cnt: got %0d expected 24", jif.bit_cnt); end
        checks++; if (jif.XJOY_DATA !== 1'b1) begin errors++; $display("FAIL frame_end_data: got %b expected 1", jif.XJOY_DATA); end
        checks++; if (jif.overrun !== 1'b0) begin errors++; $display("FAIL frame_overrun: got %b expected 0", jif.overrun); end
    endtask

    task automatic test_overrun();
        mcu_clk();
        checks++; if (jif.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", jif.overrun); end
        checks++; if (jif.XJOY_DATA !== 1'b1) begin errors++; $display("FAIL ovr_data: got %b expected 1", jif.XJOY_DATA); end
        checks++; if (jif.bit_cnt !== 5'd24) begin errors++; $display("FAIL ovr_cnt_sat: got %0d expected 24", jif.bit_cnt); end
        checks++; if (fd_cnt - fd_base !== 1) begin errors++; $display("FAIL ovr_done_count: got %0d expected 1", fd_cnt - fd_base); end
        mcu_load();
        checks++; if (jif.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", jif.overrun); end
        checks++; if (jif.bit_cnt !== 5'd0) begin errors++; $display("FAIL ovr_load_cnt: got %0d expected 0", jif.bit_cnt); end
        checks++; if (jif.XJOY_DATA !== 1'b1) begin errors++; $display("FAIL ovr_load_data: got %b expected 1", jif.XJOY_DATA); end
    endtask

    task automatic test_coincident();
        stage(24'h3C0000);
        for (int i = 0; i < 3; i++) mcu_clk();
        checks++; if (jif.bit_cnt !== 5'd3) begin errors++; $display("FAIL coin_pre_cnt: got %0d expected 3", jif.bit_cnt); end
        jif.XJOY_LOAD_N = 1'b0;
        jif.XJOY_CLK    = 1'b1;
        cyc(8);
        checks++; if (jif.bit_cnt !== 5'd0) begin errors++; $display("FAIL coin_cnt: got %0d expected 0", jif.bit_cnt); end
        checks++; if (jif.XJOY_DATA !== 1'b0) begin errors++; $display("FAIL coin_data: got %b expected 0", jif.XJOY_DATA); end
        jif.XJOY_LOAD_N = 1'b1;
        cyc(8);
        jif.XJOY_CLK = 1'b0;
        cyc(8);
        checks++; if (jif.bit_cnt !== 5'd0) begin errors++; $display("FAIL coin_release_cnt: got %0d expected 0", jif.bit_cnt); end
        jif.XJOY_CLK = 1'b1;
        cyc(1);
        jif.XJOY_CLK = 1'b0;
        cyc(12);
        checks++; if (jif.bit_cnt !== 5'd0) begin errors++; $display("FAIL glitch_cnt: got %0d expected 0", jif.bit_cnt); end
        checks++; if (jif.XJOY_DATA !== 1'b0) begin errors++; $display("FAIL glitch_data: got %b expected 0", jif.XJOY_DATA); end
        mcu_clk();
        checks++; if (jif.bit_cnt !== 5'd1) begin errors++; $display("FAIL post_glitch_cnt: got %0d expected 1", jif.bit_cnt); end
        mcu_clk();
        checks++; if (jif.XJOY_DATA !== 1'b1) begin errors++; $display("FAIL post_glitch_data: got %b expected 1", jif.XJOY_DATA); end
        checks++; if (jif.bit_cnt !== 5'd2) begin errors++; $display("FAIL post_glitch_cnt2: got %0d expected 2", jif.bit_cnt); end
    endtask

    task automatic test_stage_midframe();
        logic [23:0] w;
        stage(24'hA5F00F);
        mcu_load();
        read_frame(6, 24'h000001, w);
        checks++; if (w !== 24'hA5F00F) begin errors++; $display("FAIL mid_frame_word: got %h expected a5f00f", w); end
        checks++; if (jif.bit_cnt !== 5'd24) begin errors++; $display("FAIL mid_frame_cnt: got %0d expected 24", jif.bit_cnt); end
        mcu_load();
        read_frame(-1, 24'h0, w);
        checks++; if (w !== 24'h000001) begin errors++; $display("FAIL next_frame_word: got %h expected 000001", w); end
    endtask

    task automatic test_reset_midframe();
        logic [23:0] w;
        stage(24'h3C5296);
        mcu_load();
        for (int i = 0; i < 12; i++) mcu_clk();
        checks++; if (jif.bit_cnt !== 5'd12) begin errors++; $display("FAIL rst_mid_cnt: got %0d expected 12", jif.bit_cnt); end
        checks++; if (jif.XJOY_DATA !== 1'b0) begin errors++; $display("FAIL rst_mid_pre_data: got %b expected 0", jif.XJOY_DATA); end
        RESET_N = 1'b0;
        #1;
        checks++; if (jif.XJOY_DATA !== 1'b1) begin errors++; $display("FAIL rst_async_data: got %b expected 1", jif.XJOY_DATA); end
        checks++; if (jif.bit_cnt !== 5'd0) begin errors++; $display("FAIL rst_async_cnt: got %0d expected 0", jif.bit_cnt); end
        cyc(2);
        RESET_N = 1'b1;
        cyc(2);
        mcu_clk();
        mcu_clk();
        checks++; if (jif.XJOY_DATA !== 1'b1) begin errors++; $display("FAIL rst_idle_data: got %b expected 1", jif.XJOY_DATA); end
        checks++; if (jif.bit_cnt !== 5'd0) begin errors++; $display("FAIL rst_idle_cnt: got %0d expected 0", jif.bit_cnt); end
        stage(24'h3C5296);
        fd_base = fd_cnt;
        mcu_load();
        read_frame(-1, 24'h0, w);
        checks++; if (w !== 24'h3C5296) begin errors++; $display("FAIL rst_frame_word: got %h expected 3c5296", w); end
        checks++; if (fd_cnt - fd_base !== 1) begin errors++; $display("FAIL rst_frame_done: got %0d expected 1", fd_cnt - fd_base); end
    endtask

    initial begin
        jif.XJOY_CLK    = 1'b0;
        jif.XJOY_LOAD_N = 1'b1;
        jif.joy_state   = '0;
        jif.joy_valid   = 1'b0;
        test_reset();
        test_frame();
        test_overrun();
        test_coincident();
        test_stage_midframe();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
